// File: rtl/sram_loader_pkg.sv
// Shared definitions for the UART-to-SRAM loader and the PUF readout path.
// Optional checksum support is selected with the LOADER_CHECKSUM_EN macro.
package sram_loader_pkg;

    localparam int RAM_ADDR_W = 13;
    localparam int RAM_DATA_W = 16;

    localparam logic [7:0] DEF_CMD_BYTE = 8'h57;
    localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;
    localparam logic [7:0] DEF_ERR_BYTE = 8'h45;
    localparam logic [7:0] DEF_TMO_BYTE = 8'h54;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR_HI   = 4'd1,
        S_ADDR_LO   = 4'd2,
        S_CNT_HI    = 4'd3,
        S_CNT_LO    = 4'd4,
        S_DATA_LO   = 4'd5,
        S_DATA_HI   = 4'd6,
        S_WRITE     = 4'd7,
        S_RESP_SEND = 4'd8,
        S_RESP_WAIT = 4'd9
`ifdef LOADER_CHECKSUM_EN
        , S_CHECK   = 4'd10
`endif
    } loader_state_e;

    // States in which the host owes us another byte within the timeout window.
    function automatic logic is_timed_state(input loader_state_e s);
        logic timed;
        timed = (s == S_ADDR_HI) || (s == S_ADDR_LO) || (s == S_CNT_HI) ||
                (s == S_CNT_LO)  || (s == S_DATA_LO) || (s == S_DATA_HI);
`ifdef LOADER_CHECKSUM_EN
        timed = timed || (s == S_CHECK);
`endif
        return timed;
    endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// Inter-byte watchdog: counts enabled idle cycles, flags expiry after
// TIMEOUT_CYCLES of them; clear has priority and also masks expiry.
module loader_timeout_ctr #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [23:0] count_reg;

    assign expire = enable && !clear && (count_reg == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 24'd0;
        end else if (clear || !enable || expire) begin
            count_reg <= 24'd0;
        end else begin
            count_reg <= count_reg + 24'd1;
        end
    end

endmodule

// File: rtl/sram_uart_loader.sv
// Framed UART write command into combined_ram with a one-byte status reply.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module sram_uart_loader
    import sram_loader_pkg::*;
#(
    parameter logic [7:0]  CMD_BYTE       = DEF_CMD_BYTE,
    parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
`ifdef LOADER_CHECKSUM_EN
    parameter logic [7:0]  ERR_BYTE       = DEF_ERR_BYTE,
`endif
    parameter logic [7:0]  TMO_BYTE       = DEF_TMO_BYTE,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx_ready,
    input  logic [7:0]            uart_data_from_rx,
    input  logic                  uart_tx_ready,
    output logic [7:0]            uart_data_to_tx,
    output logic                  uart_tx_enable,
    output logic                  we,
    output logic [RAM_ADDR_W-1:0] waddr,
    output logic [RAM_DATA_W-1:0] wdata,
    output logic [RAM_DATA_W-1:0] wmask,
    output logic                  busy
);

    loader_state_e         state_reg;
    logic [RAM_ADDR_W-1:0] addr_reg;
    logic [RAM_DATA_W-1:0] wdata_reg;
    logic [15:0]           cnt_reg;
    logic [7:0]            tx_data_reg;
    logic                  tx_en_reg;
    logic                  seen_low_reg;
    logic                  tmo_expire;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_reg;
`endif

    loader_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (uart_rx_ready),
        .enable(is_timed_state(state_reg)),
        .expire(tmo_expire)
    );

    // we decodes straight from the state register so reset clears it asynchronously.
    assign we              = (state_reg == S_WRITE);
    assign waddr           = addr_reg;
    assign wdata           = wdata_reg;
    assign wmask           = '0;
    assign busy            = (state_reg != S_IDLE);
    assign uart_data_to_tx = tx_data_reg;
    assign uart_tx_enable  = tx_en_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= 16'd0;
            tx_data_reg  <= 8'h00;
            tx_en_reg    <= 1'b0;
            seen_low_reg <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_reg      <= 8'h00;
`endif
        end else begin
            tx_en_reg <= 1'b0;
            if (tmo_expire) begin
                tx_data_reg <= TMO_BYTE;
                state_reg   <= S_RESP_SEND;
            end else begin
                case (state_reg)
                    S_IDLE: begin
`ifdef LOADER_CHECKSUM_EN
                        xor_reg <= 8'h00;
`endif
                        if (uart_rx_ready && uart_data_from_rx == CMD_BYTE) begin
                            state_reg <= S_ADDR_HI;
                        end
                    end
                    S_ADDR_HI: if (uart_rx_ready) begin
                        addr_reg[12:8] <= uart_data_from_rx[4:0];
                        state_reg      <= S_ADDR_LO;
                    end
                    S_ADDR_LO: if (uart_rx_ready) begin
                        addr_reg[7:0] <= uart_data_from_rx;
                        state_reg     <= S_CNT_HI;
                    end
                    S_CNT_HI: if (uart_rx_ready) begin
                        cnt_reg[15:8] <= uart_data_from_rx;
                        state_reg     <= S_CNT_LO;
                    end
                    S_CNT_LO: if (uart_rx_ready) begin
                        cnt_reg[7:0] <= uart_data_from_rx;
                        if ({cnt_reg[15:8], uart_data_from_rx} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg   <= S_CHECK;
`else
                            tx_data_reg <= ACK_BYTE;
                            state_reg   <= S_RESP_SEND;
`endif
                        end else begin
                            state_reg <= S_DATA_LO;
                        end
                    end
                    S_DATA_LO: if (uart_rx_ready) begin
                        wdata_reg[7:0] <= uart_data_from_rx;
`ifdef LOADER_CHECKSUM_EN
                        xor_reg        <= xor_reg ^ uart_data_from_rx;
`endif
                        state_reg      <= S_DATA_HI;
                    end
                    S_DATA_HI: if (uart_rx_ready) begin
                        wdata_reg[15:8] <= uart_data_from_rx;
`ifdef LOADER_CHECKSUM_EN
                        xor_reg         <= xor_reg ^ uart_data_from_rx;
`endif
                        state_reg       <= S_WRITE;
                    end
                    S_WRITE: begin
                        // Any rx pulse landing in this single cycle is dropped.
                        addr_reg <= addr_reg + 13'd1;
                        cnt_reg  <= cnt_reg - 16'd1;
                        if (cnt_reg == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg   <= S_CHECK;
`else
                            tx_data_reg <= ACK_BYTE;
                            state_reg   <= S_RESP_SEND;
`endif
                        end else begin
                            state_reg <= S_DATA_LO;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: if (uart_rx_ready) begin
                        tx_data_reg <= (uart_data_from_rx == xor_reg) ? ACK_BYTE : ERR_BYTE;
                        state_reg   <= S_RESP_SEND;
                    end
`endif
                    S_RESP_SEND: if (uart_tx_ready) begin
                        tx_en_reg    <= 1'b1;
                        seen_low_reg <= 1'b0;
                        state_reg    <= S_RESP_WAIT;
                    end
                    S_RESP_WAIT: begin
                        // Only a ready that follows a busy phase marks the byte as sent.
                        if (!uart_tx_ready) begin
                            seen_low_reg <= 1'b1;
                        end else if (seen_low_reg) begin
                            state_reg <= S_IDLE;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_uart_loader.sv
// Directed scoreboard bench for sram_uart_loader; frames gain a checksum
// byte when LOADER_CHECKSUM_EN is defined.
module tb_sram_uart_loader;

    logic        clk;
    logic        rst_n;
    logic        uart_rx_ready;
    logic [7:0]  uart_data_from_rx;
    logic        uart_tx_ready;
    logic [7:0]  uart_data_to_tx;
    logic        uart_tx_enable;
    logic        we;
    logic [12:0] waddr;
    logic [15:0] wdata;
    logic [15:0] wmask;
    logic        busy;

    int vectors;
    int miscompares;

    logic [28:0] exp_wq[$];
    logic [7:0]  exp_txq[$];

    sram_uart_loader #(
        .TIMEOUT_CYCLES(24'd1000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .uart_rx_ready    (uart_rx_ready),
        .uart_data_from_rx(uart_data_from_rx),
        .uart_tx_ready    (uart_tx_ready),
        .uart_data_to_tx  (uart_data_to_tx),
        .uart_tx_enable   (uart_tx_enable),
        .we               (we),
        .waddr            (waddr),
        .wdata            (wdata),
        .wmask            (wmask),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        uart_rx_ready     = 1'b1;
        uart_data_from_rx = b;
        @(posedge clk);
        #1;
        uart_rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        $display("rx byte %h", b);
    endtask

    task automatic send_chk(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        send_byte(b);
`else
        if (b == 8'hFF) $display("unused chk %h", b);
`endif
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_writes_left"}, exp_wq.size(), 32'd0);
        check({tag, "_tx_left"}, exp_txq.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {31'd0, we}, 32'd0);
        check({tag, "_waddr"}, {19'd0, waddr}, 32'd0);
        check({tag, "_wdata"}, {16'd0, wdata}, 32'd0);
        check({tag, "_wmask"}, {16'd0, wmask}, 32'd0);
        check({tag, "_txen"}, {31'd0, uart_tx_enable}, 32'd0);
        check({tag, "_txdata"}, {24'd0, uart_data_to_tx}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Write monitor: every we pulse must match the head of the write scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                check("write_expected", {31'd0, exp_wq.size() != 0}, 32'd1);
                check("write_wmask", {16'd0, wmask}, 32'd0);
                if (exp_wq.size() != 0) begin
                    logic [28:0] e;
                    e = exp_wq.pop_front();
                    check("write_addr_data", {3'd0, waddr, wdata}, {3'd0, e});
                end
                $display("write addr=%h data=%h", waddr, wdata);
            end
        end
    end

    // TX monitor: each tx_enable pulse pops one expected status byte.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx_enable === 1'b1) begin
                check("tx_expected", {31'd0, exp_txq.size() != 0}, 32'd1);
                if (exp_txq.size() != 0) begin
                    logic [7:0] t;
                    t = exp_txq.pop_front();
                    check("tx_byte", {24'd0, uart_data_to_tx}, {24'd0, t});
                end
                $display("tx byte %h", uart_data_to_tx);
            end
        end
    end

    // UART transmitter model: goes busy after a request, idle again later.
    initial begin
        uart_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_tx_enable === 1'b1) begin
                @(posedge clk);
                #1 uart_tx_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 uart_tx_ready = 1'b1;
            end
        end
    end

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        uart_rx_ready     = 1'b0;
        uart_data_from_rx = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two words at 0x010
        exp_wq.push_back({13'h0010, 16'h1234});
        exp_wq.push_back({13'h0011, 16'h5678});
        exp_txq.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
        send_chk(8'h08);
        wait_idle("frame1", 200);

        // Address wrap at the top of the RAM
        exp_wq.push_back({13'h1FFF, 16'hBBAA});
        exp_wq.push_back({13'h0000, 16'hDDCC});
        exp_txq.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h1F); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_chk(8'h00);
        wait_idle("wrap", 200);

        // Junk before command, zero-length frame
        exp_txq.push_back(8'h4B);
        send_byte(8'h41); send_byte(8'h00);
        check("junk_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        send_chk(8'h00);
        wait_idle("zero_len", 200);

        // Timeout after one of three words
        exp_wq.push_back({13'h0000, 16'h2211});
        exp_txq.push_back(8'h54);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22);
        wait_idle("timeout", 3000);

        // Reset in the middle of a word
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h34);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        exp_wq.push_back({13'h0005, 16'hBEEF});
        exp_txq.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hEF); send_byte(8'hBE);
        send_chk(8'h51);
        wait_idle("after_reset", 200);

`ifdef LOADER_CHECKSUM_EN
        exp_wq.push_back({13'h0000, 16'h1234});
        exp_txq.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h26);
        wait_idle("chk_good", 200);

        exp_wq.push_back({13'h0000, 16'h1234});
        exp_txq.push_back(8'h45);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h27);
        wait_idle("chk_bad", 200);
`endif

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
